// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : FIFO for ALU results. On each write it keeps either the
//               ALU result or the multiplier product, depending on the
//               opcode. It stores the opcode and the carry/zero flags with
//               that value. Build option ALU_RESULT_STICKY_EN adds sticky
//               carry/zero flags and a clear input for them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
  parameter int         DEPTH      = 4,
  parameter logic [2:0] MUL_OPCODE = 3'b010
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_opcode,
  input  logic [15:0]                in_result,
  input  logic [15:0]                in_result1,
  input  logic                       in_flagC,
  input  logic                       in_flagZ,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_opcode,
  output logic [15:0]                out_data,
  output logic                       out_flagC,
  output logic                       out_flagZ,
  output logic [$clog2(DEPTH):0]     count
`ifdef ALU_RESULT_STICKY_EN
  ,
  input  logic                       sticky_clr,
  output logic                       sticky_c,
  output logic                       sticky_z
`endif
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE   = C_PTR_W'(1);

  typedef struct packed {
    logic [2:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] data;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]   count_q, count_d;

  logic                 w_wr_en;
  logic                 w_rd_en;
  entry_t               w_wr_entry;
  entry_t               w_head;

  // Handshake status comes only from the registered count.
  always_comb begin
    in_ready  = (count_q < C_DEPTH_CNT);
    out_valid = (count_q != '0);
    w_wr_en   = in_valid && in_ready && !rst;
    w_rd_en   = out_valid && out_ready && !rst;
  end

  // Choose the stored value: the product for multiplies, else the ALU result.
  always_comb begin
    w_wr_entry.opcode = in_opcode;
    if (in_opcode == MUL_OPCODE) begin
      w_wr_entry.data   = in_result1;
      w_wr_entry.flag_c = 1'b0;
      w_wr_entry.flag_z = (in_result1 == 16'h0000);
    end else begin
      w_wr_entry.data   = in_result;
      w_wr_entry.flag_c = in_flagC;
      w_wr_entry.flag_z = in_flagZ;
    end
  end

  // Next-state logic for the storage, the pointers and the occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_en) begin
      mem_d[wr_ptr_q] = w_wr_entry;
      wr_ptr_d        = wr_ptr_q + C_PTR_ONE;   // power-of-two depth wraps naturally
    end
    if (w_rd_en) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
    case ({w_wr_en, w_rd_en})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage array is not reset. Occupancy is tracked only by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head outputs read as zero whenever the FIFO is empty.
  always_comb begin
    w_head     = mem_q[rd_ptr_q];
    out_opcode = out_valid ? w_head.opcode : 3'b000;
    out_data   = out_valid ? w_head.data   : 16'h0000;
    out_flagC  = out_valid && w_head.flag_c;
    out_flagZ  = out_valid && w_head.flag_z;
    count      = count_q;
  end

`ifdef ALU_RESULT_STICKY_EN
  logic sticky_c_q, sticky_c_d;
  logic sticky_z_q, sticky_z_d;

  // A set on a write takes priority over a clear in the same cycle.
  always_comb begin
    sticky_c_d = (sticky_c_q && !sticky_clr) || (w_wr_en && w_wr_entry.flag_c);
    sticky_z_d = (sticky_z_q && !sticky_clr) || (w_wr_en && w_wr_entry.flag_z);
  end

  // Sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_c_q <= 1'b0;
      sticky_z_q <= 1'b0;
    end else begin
      sticky_c_q <= sticky_c_d;
      sticky_z_q <= sticky_z_d;
    end
  end

  assign sticky_c = sticky_c_q;
  assign sticky_z = sticky_z_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_fifo
// Description : Directed self-checking bench for alu_result_fifo (DEPTH=4).
//               It also exercises the sticky flags when ALU_RESULT_STICKY_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [15:0] in_result;
  logic [15:0] in_result1;
  logic        in_flagC;
  logic        in_flagZ;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [15:0] out_data;
  logic        out_flagC;
  logic        out_flagZ;
  logic [2:0]  count;
`ifdef ALU_RESULT_STICKY_EN
  logic        sticky_clr;
  logic        sticky_c;
  logic        sticky_z;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(4), .MUL_OPCODE(3'b010)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_result  (in_result),
    .in_result1 (in_result1),
    .in_flagC   (in_flagC),
    .in_flagZ   (in_flagZ),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_data   (out_data),
    .out_flagC  (out_flagC),
    .out_flagZ  (out_flagZ),
    .count      (count)
`ifdef ALU_RESULT_STICKY_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_c   (sticky_c),
    .sticky_z   (sticky_z)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [15:0] res, input logic [15:0] res1,
                      input logic c, input logic z);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_result  = res;
    in_result1 = res1;
    in_flagC   = c;
    in_flagZ   = z;
    tick();
    in_valid   = 1'b0;
  endtask

  logic [15:0] q[$];
  logic [2:0]  fill_op   [5] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [15:0] fill_data [5] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_result = '0; in_result1 = '0; in_flagC = 1'b0; in_flagZ = 1'b0;
`ifdef ALU_RESULT_STICKY_EN
    sticky_clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_eq("rst_count",     32'(count),     32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_out_flags", 32'({out_opcode, out_flagC, out_flagZ}), 32'd0);

    // Basic write. There must be no same-cycle pass-through.
    in_valid = 1'b1; in_opcode = 3'b000; in_result = 16'h00C8; in_result1 = 16'h5555;
    in_flagC = 1'b0; in_flagZ = 1'b0;
    #1;
    check_eq("no_passthru", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check_eq("w1_valid", 32'(out_valid), 32'd1);
    check_eq("w1_data",  32'(out_data),  32'h00C8);
    check_eq("w1_count", 32'(count),     32'd1);

    // Multiply opcode takes in_result1 and forces the flags.
    push(3'b010, 16'h1234, 16'h3840, 1'b1, 1'b1);
    tick();
    check_eq("hold_data",  32'(out_data), 32'h00C8);
    check_eq("mul_count",  32'(count),    32'd2);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_eq("mul_data",   32'(out_data),   32'h3840);
    check_eq("mul_opcode", 32'(out_opcode), 32'd2);
    check_eq("mul_flagC",  32'(out_flagC),  32'd0);
    check_eq("mul_flagZ",  32'(out_flagZ),  32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_eq("drain_empty", 32'(out_valid), 32'd0);

    // A multiply with a zero product sets flagZ and clears flagC.
    push(3'b010, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    check_eq("mulz_valid", 32'(out_valid), 32'd1);
    check_eq("mulz_data",  32'(out_data),  32'h0000);
    check_eq("mulz_flags", 32'({out_flagC, out_flagZ}), 32'b01);
    out_ready = 1'b1; tick();
    // out_ready is ignored when the FIFO is empty
    tick(); out_ready = 1'b0;
    check_eq("empty_rd_ign", 32'(count), 32'd0);

    // Fill past DEPTH. The fifth entry is dropped.
    for (int i = 0; i < 5; i++) begin
      push(fill_op[i], fill_data[i], ~fill_data[i], i[0], i[1]);
      check_eq($sformatf("fill_count%0d", i), 32'(count), (i < 4) ? i + 1 : 4);
    end
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drain_data%0d", i),  32'(out_data),   32'(fill_data[i]));
      check_eq($sformatf("drain_op%0d", i),    32'(out_opcode), 32'(fill_op[i]));
      check_eq($sformatf("drain_flg%0d", i),   32'({out_flagC, out_flagZ}), 32'({i[0], i[1]}));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    check_eq("drain_count", 32'(count), 32'd0);

    // Simultaneous write and read at count=2, wrapping the pointers.
    q = {};
    push(3'b000, 16'h0100, 16'h0, 1'b0, 1'b0); q.push_back(16'h0100);
    push(3'b000, 16'h0101, 16'h0, 1'b0, 1'b0); q.push_back(16'h0101);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_opcode = 3'b100; in_result = 16'h0200 + 16'(i); out_ready = 1'b1;
      check_eq($sformatf("rw_head%0d", i), 32'(out_data), 32'(q[0]));
      tick();
      void'(q.pop_front());
      q.push_back(16'h0200 + 16'(i));
      check_eq($sformatf("rw_count%0d", i), 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rw_tail%0d", i), 32'(out_data), 32'(q[0]));
      tick(); void'(q.pop_front());
    end
    out_ready = 1'b0;
    check_eq("rw_empty", 32'(count), 32'd0);

    // Full with a simultaneous read. The write is ignored and the read frees a slot.
    for (int i = 0; i < 4; i++) push(3'b000, 16'h0300 + 16'(i), 16'h0, 1'b0, 1'b0);
    in_valid = 1'b1; in_opcode = 3'b000; in_result = 16'hDEAD; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("fullrd_count", 32'(count),    32'd3);
    check_eq("fullrd_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      check_eq($sformatf("fullrd_data%0d", i), 32'(out_data), 32'h0300 + i);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    check_eq("fullrd_empty", 32'(out_valid), 32'd0);

    // Reset in the middle of operation. The write and read in that cycle are ignored.
    for (int i = 0; i < 3; i++) push(3'b001, 16'h0400 + 16'(i), 16'h0, 1'b0, 1'b0);
    check_eq("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1; in_valid = 1'b1; in_result = 16'h0BAD; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("mrst_count", 32'(count),     32'd0);
    check_eq("mrst_valid", 32'(out_valid), 32'd0);
    check_eq("mrst_data",  32'(out_data),  32'd0);
    check_eq("mrst_ready", 32'(in_ready),  32'd1);
    push(3'b000, 16'h7777, 16'h0, 1'b0, 1'b0);
    check_eq("post_rst_data", 32'(out_data), 32'h7777);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

`ifdef ALU_RESULT_STICKY_EN
    // The sticky flag sets on a write. A set wins over a clear in the same cycle.
    check_eq("stk_init", 32'(sticky_c), 32'd0);
    push(3'b001, 16'h0001, 16'h0, 1'b1, 1'b0);
    check_eq("stk_set", 32'(sticky_c), 32'd1);
    sticky_clr = 1'b1;
    push(3'b001, 16'h0002, 16'h0, 1'b1, 1'b0);
    check_eq("stk_set_clr", 32'(sticky_c), 32'd1);
    tick();
    sticky_clr = 1'b0;
    check_eq("stk_clr", 32'(sticky_c), 32'd0);
    push(3'b010, 16'h0003, 16'h0000, 1'b1, 1'b0);
    check_eq("stk_z_mul", 32'({sticky_c, sticky_z}), 32'b01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries; power of two, 2..16.
REQ-002 Parameter MUL_OPCODE, default 3'b010, opcode whose product is taken from the multiplier output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream ALU result present this cycle.
REQ-006 in_ready  output  1  block accepts an entry this cycle.
REQ-007 in_opcode  input  3  ALU opcode of the result.
REQ-008 in_result  input  16  ALU logic/add/sub result.
REQ-009 in_result1  input  16  Vedic multiplier product.
REQ-010 in_flagC  input  1  ALU carry flag.
REQ-011 in_flagZ  input  1  ALU zero flag.
REQ-012 out_valid  output  1  head entry available.
REQ-013 out_ready  input  1  downstream consumes head entry this cycle.
REQ-014 out_opcode  output  3  head entry opcode.
REQ-015 out_data  output  16  head entry selected result.
REQ-016 out_flagC  output  1  head entry carry flag.
REQ-017 out_flagZ  output  1  head entry zero flag.
REQ-018 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-019 sticky_clr  input  1  clears sticky flags (present only with ALU_RESULT_STICKY_EN).
REQ-020 sticky_c, sticky_z  output  1 each  sticky carry/zero (present only with ALU_RESULT_STICKY_EN).

Function
REQ-021 Write occurs when in_valid && in_ready; read occurs when out_valid && out_ready.
REQ-022 in_ready SHALL be 1 iff count < DEPTH; out_valid SHALL be 1 iff count != 0; both derived from registered count only.
REQ-023 On write, stored data = in_result1 if in_opcode == MUL_OPCODE, else in_result.
REQ-024 On write with in_opcode == MUL_OPCODE, stored flagC = 0 and stored flagZ = (in_result1 == 0); otherwise in_flagC/in_flagZ stored unchanged.
REQ-025 Latency: an entry written into an empty FIFO at edge N SHALL appear with out_valid=1 in the cycle after edge N; no combinational pass-through.
REQ-026 Order SHALL be strictly first-in first-out.
REQ-027 Simultaneous write and read (0 < count < DEPTH): count unchanged, both pointers advance.
REQ-028 Full: in_ready=0, in_valid ignored; a read in the same cycle frees a slot usable from the next cycle.
REQ-029 Empty: out_ready ignored; out_opcode, out_data, out_flagC, out_flagZ SHALL be 0.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 Head outputs SHALL stay stable while out_valid && !out_ready.
REQ-032 Input fields SHALL be sampled only on a write edge; values while in_ready=0 have no effect.

Reset
REQ-033 rst=1 at a rising edge SHALL set count=0, both pointers=0, sticky flags=0; outputs are then in_ready=1, out_valid=0, head fields 0.
REQ-034 Reset mid-operation SHALL discard all stored entries; a write or read in the reset cycle SHALL be ignored.
REQ-035 Storage array contents need not be cleared by reset.

Configuration
REQ-036 Macro ALU_RESULT_STICKY_EN defined: sticky_c/sticky_z SHALL set to 1 on any write whose stored flagC/flagZ is 1, and clear on sticky_clr=1; a simultaneous set and clear SHALL leave the flag at 1.
REQ-037 Macro undefined: sticky_clr, sticky_c, sticky_z ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-038 Reset, then write opcode 000, result 16'h00C8, flagC=0, flagZ=0 -> next cycle out_valid=1, out_data=16'h00C8, count=1.
REQ-039 Write opcode 010, in_result=16'h1234, in_result1=16'h3840 (0xF0*0x3C) -> out_data=16'h3840, out_flagC=0, out_flagZ=0.
REQ-040 Hold out_ready=0, write 5 entries with DEPTH=4 -> count=4, in_ready=0 after 4th, 5th entry dropped; drain yields first 4 in order.
REQ-041 At count=2, assert write and read together for 10 cycles -> count stays 2, output sequence matches input order across pointer wrap.
REQ-042 With count=3, assert rst with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0.
REQ-043 ALU_RESULT_STICKY_EN: write opcode 001 with flagC=1, then sticky_clr=1 with another flagC=1 write -> sticky_c=1 after both edges; sticky_clr alone -> sticky_c=0.
